sti_serializer: RTL and testbench
=================================

# sti_serializer

Parallel-to-serial transmitter directly upstream of the data-arrange controller. Accepts one 16-bit word per `load` pulse, formats it into an 8/16/24/32-bit frame (byte select, zero fill, bit order), and shifts it out one bit per clock on `so_data`/`so_valid`. After the last word, flagged by `pi_end`, it drives `final_valid` so the downstream stage can zero-pad its remaining pages. It holds `final_valid` until that stage reports `oem_finish`.

## Interface
- No parameters; frame widths are fixed by the `pi_length` encoding.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; all state cleared while low.
- `load` in 1: single-cycle strobe; samples all `pi_*` inputs. Ignored while `busy`=1.
- `pi_data` in 16: input word.
- `pi_length` in 2: frame length. 00=8, 01=16, 10=24, 11=32 bits.
- `pi_fill` in 1: zero placement for 24/32-bit frames. 1: data in MSBs, zeros in LSBs. 0: zeros in MSBs, data in LSBs.
- `pi_msb` in 1: 1 = frame MSB sent first, 0 = LSB first.
- `pi_low` in 1: 8-bit frames only. 1 = `pi_data[15:8]`, 0 = `pi_data[7:0]`.
- `pi_end` in 1: this word is the last one.
- `oem_finish` in 1: downstream has completed all pages.
- `busy` out 1: high while transmitting, in FINAL, or in DONE.
- `so_data` out 1: serial bit; 0 whenever `so_valid`=0.
- `so_valid` out 1: `so_data` is valid this cycle.
- `final_valid` out 1: end-of-stream padding request.

## Operation
- Frame build from the sampled inputs, N = frame length:
  - 8-bit: the selected byte.
  - 16-bit: `pi_data`.
  - 24-bit: fill ? {`pi_data`, 8'h00} : {8'h00, `pi_data`}.
  - 32-bit: fill ? {`pi_data`, 16'h0000} : {16'h0000, `pi_data`}.
- Frame held in a 32-bit register. 5-bit bit counter counts 0..N-1.
- Emitted bit index: msb ? N-1-cnt : cnt.
- States:
  - IDLE: `busy`=0. On `load` → SHIFT, capturing frame, N, msb and end.
  - SHIFT: `so_valid`=1; one bit per cycle. After bit N-1: end=0 → IDLE; end=1 → FINAL.
  - FINAL: `final_valid`=1, `busy`=1. When `oem_finish`=1 is sampled → DONE.
  - DONE: all outputs 0 except `busy`=1. Terminal until reset.
- `load` while `busy`=1 is dropped entirely: no queueing, no capture.
- `pi_fill` is ignored for 8/16-bit frames. `pi_low` is ignored for frames other than 8-bit.

## Timing
- Reset values: `busy`=0, `so_data`=0, `so_valid`=0, `final_valid`=0; state IDLE; counter 0; frame register 0.
- `load` sampled at edge T: `so_valid`=1 and the first bit appear in the cycle after T. `busy` rises in the same cycle.
- `so_valid` stays high for exactly N consecutive cycles with no gaps.
- In the cycle after the last bit:
  - end=0: `busy`=0 and `so_valid`=0. The earliest accepted next `load` is in that cycle, so there is a minimum 1 idle cycle between frames.
  - end=1: `final_valid`=1 in that cycle, with no gap cycle.
- `final_valid` falls in the cycle after the edge that samples `oem_finish`=1.
- `oem_finish` high outside FINAL has no effect.
- All outputs are registered; there are no combinational input-to-output paths.
- `reset` asserted mid-frame: outputs go to reset values immediately (asynchronous). The partial frame is discarded. After release, the block is in IDLE.

## Structure
- Package `sti_pkg` holds:
  - length encodings `LEN_8`/`LEN_16`/`LEN_24`/`LEN_32`;
  - state enum {IDLE, SHIFT, FINAL, DONE};
  - a function mapping a length code to N-1 (5 bits).
- One combinational sub-module, `sti_frame_align`: inputs `pi_data`, `pi_length`, `pi_fill`, `pi_low`; output a 32-bit frame. The top level holds the FSM, counter and frame register.

## Test plan
- 8-bit, low=0, msb=1, data 16'hA5C3 → 8 valid cycles: 1,1,0,0,0,0,1,1. Then `busy`=0 and `so_valid`=0.
- 16-bit, msb=0, data 16'h8001 → bit0=1, then 14 zeros, then 1. `so_valid` high for exactly 16 cycles.
- 24-bit, msb=1, data 16'hFFFF:
  - fill=1 → 16 ones then 8 zeros.
  - repeated with fill=0 → 8 zeros then 16 ones.
- 32-bit, fill=0, msb=0, data 16'h0001 → 1 then 31 zeros. A `load` pulsed mid-frame is ignored; the stream is unchanged.
- Last word 8-bit with end=1 → `final_valid`=1 starting the cycle after bit 8. `oem_finish` pulsed 20 cycles later → `final_valid`=0 next cycle. A later `load` produces no output.
- `reset` low during bit 5 of a 16-bit frame → all outputs 0 immediately. After release, a new 8-bit load transmits correctly.

Source files
------------

// File: rtl/sti_serializer_pkg.sv
// Shared definitions for the serial transmitter: length codes, FSM states
// and the length-code to last-bit-index mapping.
package sti_pkg;

    localparam logic [1:0] LEN_8  = 2'b00;
    localparam logic [1:0] LEN_16 = 2'b01;
    localparam logic [1:0] LEN_24 = 2'b10;
    localparam logic [1:0] LEN_32 = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } sti_state_e;

    // Index of the last bit of a frame (N-1) for a given length code.
    function automatic logic [4:0] len_last_bit(input logic [1:0] len);
        logic [4:0] last;
        case (len)
            LEN_8:   last = 5'd7;
            LEN_16:  last = 5'd15;
            LEN_24:  last = 5'd23;
            default: last = 5'd31;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/sti_serializer_if.sv
// Load/format inputs, end-of-stream handshake and serial outputs of the
// transmitter. master = the side that loads words, slave = the transmitter.
interface sti_serializer_if;

    logic        load;
    logic [15:0] pi_data;
    logic [1:0]  pi_length;
    logic        pi_fill;
    logic        pi_msb;
    logic        pi_low;
    logic        pi_end;
    logic        oem_finish;
    logic        busy;
    logic        so_data;
    logic        so_valid;
    logic        final_valid;

    modport master (
        output load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end,
        output oem_finish,
        input  busy, so_data, so_valid, final_valid
    );

    modport slave (
        input  load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end,
        input  oem_finish,
        output busy, so_data, so_valid, final_valid
    );

endinterface

// File: rtl/sti_frame_align.sv
// Places the 16-bit input word into a right-justified 32-bit frame:
// byte select for 8-bit frames, zero fill position for 24/32-bit frames.
module sti_frame_align
    import sti_pkg::*;
(
    input  logic [15:0] pi_data,
    input  logic [1:0]  pi_length,
    input  logic        pi_fill,
    input  logic        pi_low,
    output logic [31:0] frame
);

    // Frame build; bits above N-1 are always zero.
    always_comb begin
        frame = 32'h0;
        case (pi_length)
            LEN_8:   frame = {24'h0, (pi_low ? pi_data[15:8] : pi_data[7:0])};
            LEN_16:  frame = {16'h0, pi_data};
            LEN_24:  frame = pi_fill ? {8'h0, pi_data, 8'h00} : {16'h0, pi_data};
            default: frame = pi_fill ? {pi_data, 16'h0000} : {16'h0000, pi_data};
        endcase
    end

endmodule

// File: rtl/sti_serializer.sv
// Parallel-to-serial transmitter. Captures one formatted word per load,
// shifts it out one bit per clock, then raises final_valid after the last
// word until the downstream stage reports oem_finish.
//
// state | meaning
// IDLE  | waiting for load, busy=0
// SHIFT | emitting frame bits, so_valid=1
// FINAL | last word sent, final_valid=1 until oem_finish
// DONE  | stream complete, busy=1, terminal until reset
module sti_serializer
    import sti_pkg::*;
(
    input  logic clk,
    input  logic reset,
    sti_serializer_if.slave bus
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_SHIFT = SHIFT;
    localparam logic [1:0] ST_FINAL = FINAL;
    localparam logic [1:0] ST_DONE  = DONE;

    logic [1:0]  state_q;
    logic [4:0]  cnt_q;
    logic [4:0]  last_q;
    logic [31:0] frame_q;
    logic        msb_q;
    logic        end_q;
    logic        busy_q;
    logic        so_data_q;
    logic        so_valid_q;
    logic        final_valid_q;

    logic [31:0] frame_in;
    logic [4:0]  load_last;
    logic [4:0]  load_idx;
    logic [4:0]  cnt_inc;
    logic [4:0]  next_idx;

    sti_frame_align u_align (
        .pi_data   (bus.pi_data),
        .pi_length (bus.pi_length),
        .pi_fill   (bus.pi_fill),
        .pi_low    (bus.pi_low),
        .frame     (frame_in)
    );

    // Bit selection for the first bit of a new frame and the following bit
    // of the current one; outputs are registered so these are one bit ahead.
    always_comb begin
        load_last = len_last_bit(bus.pi_length);
        load_idx  = bus.pi_msb ? load_last : 5'd0;
        cnt_inc   = cnt_q + 5'd1;
        next_idx  = msb_q ? (last_q - cnt_inc) : cnt_inc;
    end

    // FSM, bit counter, frame register and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 5'd0;
            last_q        <= 5'd0;
            frame_q       <= 32'h0;
            msb_q         <= 1'b0;
            end_q         <= 1'b0;
            busy_q        <= 1'b0;
            so_data_q     <= 1'b0;
            so_valid_q    <= 1'b0;
            final_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.load) begin
                        state_q    <= ST_SHIFT;
                        frame_q    <= frame_in;
                        last_q     <= load_last;
                        msb_q      <= bus.pi_msb;
                        end_q      <= bus.pi_end;
                        cnt_q      <= 5'd0;
                        busy_q     <= 1'b1;
                        so_valid_q <= 1'b1;
                        so_data_q  <= frame_in[load_idx];
                    end
                end
                ST_SHIFT: begin
                    if (cnt_q == last_q) begin
                        so_valid_q <= 1'b0;
                        so_data_q  <= 1'b0;
                        if (end_q) begin
                            state_q       <= ST_FINAL;
                            final_valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q     <= cnt_inc;
                        so_data_q <= frame_q[next_idx];
                    end
                end
                ST_FINAL: begin
                    if (bus.oem_finish) begin
                        state_q       <= ST_DONE;
                        final_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_DONE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.so_data     = so_data_q;
    assign bus.so_valid    = so_valid_q;
    assign bus.final_valid = final_valid_q;

endmodule

// File: tb/tb_sti_serializer.sv
// Self-checking bench for sti_serializer: directed frames from the test plan
// plus randomized frames checked against a behavioural stream model.
module tb_sti_serializer;

    logic clk;
    logic reset;
    int   checks_total;
    int   checks_passed;

    sti_serializer_if bus_if ();

    sti_serializer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected serial stream, first transmitted bit in bit 31.
    function automatic logic [31:0] ref_stream(input logic [15:0] data, input logic [1:0] len,
                                               input logic fill, input logic msb, input logic low);
        int unsigned fr;
        int unsigned n;
        int unsigned idx;
        logic [31:0] s;
        n = 8 * (int'(len) + 1);
        case (len)
            2'd0:    fr = low ? (int'(data) / 256) : (int'(data) % 256);
            2'd1:    fr = data;
            2'd2:    fr = fill ? int'(data) * 256 : int'(data);
            default: fr = fill ? int'(data) * 65536 : int'(data);
        endcase
        s = 32'h0;
        for (int i = 0; i < int'(n); i++) begin
            idx = msb ? (n - 1 - i) : i;
            s[31 - i] = ((fr >> idx) & 1) != 0;
        end
        return s;
    endfunction

    // Called at a negedge with the block idle. Pulses load and checks every
    // bit plus the cycle after the frame. mid_load >= 0 re-pulses load with
    // different inputs during that bit, which must be ignored.
    task automatic send_frame(input logic [15:0] data, input logic [1:0] len, input logic fill,
                              input logic msb, input logic low, input logic endf,
                              input logic [31:0] exp, input int mid_load, input string name);
        int n;
        n = 8 * (int'(len) + 1);
        bus_if.pi_data   = data;
        bus_if.pi_length = len;
        bus_if.pi_fill   = fill;
        bus_if.pi_msb    = msb;
        bus_if.pi_low    = low;
        bus_if.pi_end    = endf;
        bus_if.load      = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0 || i == mid_load + 1) bus_if.load = 1'b0;
            checks_total++;
            if ({bus_if.so_valid, bus_if.so_data, bus_if.busy} !== {1'b1, exp[31 - i], 1'b1}) begin
                $display("FAIL %s bit %0d: valid/data/busy got %b%b%b want 1%b1", name, i,
                         bus_if.so_valid, bus_if.so_data, bus_if.busy, exp[31 - i]);
            end else begin
                checks_passed++;
            end
            if (i == mid_load) begin
                bus_if.pi_data   = ~data;
                bus_if.pi_msb    = ~msb;
                bus_if.pi_length = ~len;
                bus_if.pi_end    = ~endf;
                bus_if.load      = 1'b1;
            end
        end
        @(negedge clk);
        checks_total++;
        if ({bus_if.so_valid, bus_if.so_data, bus_if.busy, bus_if.final_valid} !==
            {1'b0, 1'b0, endf, endf}) begin
            $display("FAIL %s after-frame: valid/data/busy/final got %b%b%b%b want 00%b%b", name,
                     bus_if.so_valid, bus_if.so_data, bus_if.busy, bus_if.final_valid, endf, endf);
        end else begin
            checks_passed++;
        end
    endtask

    task automatic test_reset();
        reset             = 1'b0;
        bus_if.load       = 1'b0;
        bus_if.pi_data    = 16'h0;
        bus_if.pi_length  = 2'b00;
        bus_if.pi_fill    = 1'b0;
        bus_if.pi_msb     = 1'b0;
        bus_if.pi_low     = 1'b0;
        bus_if.pi_end     = 1'b0;
        bus_if.oem_finish = 1'b0;
        #12;
        checks_total++;
        if ({bus_if.busy, bus_if.so_data, bus_if.so_valid, bus_if.final_valid} !== 4'b0000)
            $display("FAIL reset_held: outputs got %b%b%b%b want 0000", bus_if.busy,
                     bus_if.so_data, bus_if.so_valid, bus_if.final_valid);
        else checks_passed++;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks_total++;
        if ({bus_if.busy, bus_if.so_data, bus_if.so_valid, bus_if.final_valid} !== 4'b0000)
            $display("FAIL reset_release: outputs got %b%b%b%b want 0000", bus_if.busy,
                     bus_if.so_data, bus_if.so_valid, bus_if.final_valid);
        else checks_passed++;
    endtask

    task automatic test_8bit();
        send_frame(16'hA5C3, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 32'hC300_0000, -1, "len8_a5c3");
    endtask

    task automatic test_16bit();
        bus_if.oem_finish = 1'b1;
        send_frame(16'h8001, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8001_0000, -1, "len16_8001");
        bus_if.oem_finish = 1'b0;
    endtask

    task automatic test_24bit();
        send_frame(16'hFFFF, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_0000, -1, "len24_fill1");
        send_frame(16'hFFFF, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00FF_FF00, -1, "len24_fill0");
    endtask

    task automatic test_32bit_mid_load();
        send_frame(16'h0001, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 10, "len32_midload");
    endtask

    task automatic test_random();
        logic [15:0] d;
        logic [1:0]  len;
        logic        fill, msb, low;
        int          mid;
        for (int k = 0; k < 24; k++) begin
            d    = 16'($urandom);
            len  = 2'($urandom_range(0, 3));
            fill = 1'($urandom);
            msb  = 1'($urandom);
            low  = 1'($urandom);
            mid  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1;
            send_frame(d, len, fill, msb, low, 1'b0, ref_stream(d, len, fill, msb, low), mid,
                       "random");
        end
    endtask

    task automatic test_final();
        logic ok;
        send_frame(16'h005A, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, ref_stream(16'h005A, 2'b00, 1'b0, 1'b1, 1'b0),
                   -1, "final_frame");
        ok = 1'b1;
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            if ({bus_if.final_valid, bus_if.busy, bus_if.so_valid} !== 3'b110) ok = 1'b0;
        end
        checks_total++;
        if (ok !== 1'b1) $display("FAIL final_hold: final_valid/busy not held, got %b want 1", ok);
        else checks_passed++;
        bus_if.oem_finish = 1'b1;
        @(negedge clk);
        bus_if.oem_finish = 1'b0;
        checks_total++;
        if ({bus_if.final_valid, bus_if.busy} !== 2'b01)
            $display("FAIL final_release: final/busy got %b%b want 01", bus_if.final_valid,
                     bus_if.busy);
        else checks_passed++;
        bus_if.pi_data   = 16'hFFFF;
        bus_if.pi_length = 2'b01;
        bus_if.pi_end    = 1'b0;
        bus_if.load      = 1'b1;
        @(negedge clk);
        bus_if.load = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if ({bus_if.so_valid, bus_if.so_data, bus_if.busy, bus_if.final_valid} !== 4'b0010)
                ok = 1'b0;
            @(negedge clk);
        end
        checks_total++;
        if (ok !== 1'b1) $display("FAIL done_ignores_load: outputs changed, got %b want 1", ok);
        else checks_passed++;
    endtask

    task automatic test_reset_midframe();
        logic [15:0] d;
        logic [31:0] exp;
        logic        msb;
        reset = 1'b0;
        #3;
        reset = 1'b1;
        @(negedge clk);
        d   = 16'($urandom);
        msb = 1'($urandom);
        exp = ref_stream(d, 2'b01, 1'b0, msb, 1'b0);
        bus_if.pi_data   = d;
        bus_if.pi_length = 2'b01;
        bus_if.pi_msb    = msb;
        bus_if.pi_end    = 1'b0;
        bus_if.load      = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus_if.load = 1'b0;
            checks_total++;
            if ({bus_if.so_valid, bus_if.so_data} !== {1'b1, exp[31 - i]})
                $display("FAIL pre_reset bit %0d: valid/data got %b%b want 1%b", i,
                         bus_if.so_valid, bus_if.so_data, exp[31 - i]);
            else checks_passed++;
        end
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks_total++;
        if ({bus_if.busy, bus_if.so_data, bus_if.so_valid, bus_if.final_valid} !== 4'b0000)
            $display("FAIL async_reset: outputs got %b%b%b%b want 0000", bus_if.busy,
                     bus_if.so_data, bus_if.so_valid, bus_if.final_valid);
        else checks_passed++;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks_total++;
        if ({bus_if.busy, bus_if.so_valid} !== 2'b00)
            $display("FAIL post_reset_idle: busy/valid got %b%b want 00", bus_if.busy,
                     bus_if.so_valid);
        else checks_passed++;
        d = 16'($urandom);
        send_frame(d, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, ref_stream(d, 2'b00, 1'b0, 1'b1, 1'b1), -1,
                   "after_reset_len8");
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        test_reset();
        test_8bit();
        test_16bit();
        test_24bit();
        test_32bit_mid_load();
        test_random();
        test_final();
        test_reset_midframe();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
